// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//
// Memory-side responder for the load/store path. Accepts one word-aligned
// request at a time, waits WAIT_CYCLES extra cycles, then performs either a
// byte-masked write or a full-word read on an internal word RAM. Returns the
// raw 32-bit word; lane extraction and sign extension are done upstream.
//
// Parameters:
//   ADDR_WIDTH  - RAM depth is 2**ADDR_WIDTH words (must be < 30)
//   BASE_WORD   - word address (addr[31:2]) that maps to RAM index 0
//   WAIT_CYCLES - extra latency cycles per access, 0..15
//
// Ports:
//   clk           - rising-edge clock
//   rst           - synchronous, active-high reset
//   req_valid     - request present
//   req_ready     - responder can accept a request (IDLE and not in reset)
//   req_we        - 1 = store, 0 = load
//   addr_to_mem   - word address [31:2]
//   be            - byte enables, lane i = bits [8i+7:8i]
//   data_to_mem   - lane-replicated write data
//   data_from_mem - registered read word (0 on a faulting access)
//   resp_valid    - one-cycle response strobe
//   resp_err      - fault flag, qualified by resp_valid
// -----------------------------------------------------------------------------
module dmem_responder #(
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter logic [29:0] BASE_WORD   = 30'h0,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [29:0] addr_to_mem,
    input  logic [3:0]  be,
    input  logic [31:0] data_to_mem,
    output logic [31:0] data_from_mem,
    output logic        resp_valid,
    output logic        resp_err
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    // Counter reload value on WAIT entry; unused when WAIT_CYCLES is 0.
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    logic [1:0]  state;
    logic [3:0]  wait_cnt;

    // Request fields captured at the accept edge.
    logic        lat_we;
    logic [29:0] lat_addr;
    logic [3:0]  lat_be;
    logic [31:0] lat_data;

    logic [31:0] mem [DEPTH];

    logic        accept;
    logic        access;
    logic        acc_we;
    logic [29:0] acc_addr;
    logic [3:0]  acc_be;
    logic [31:0] acc_data;
    logic [29:0] idx_full;
    logic [ADDR_WIDTH-1:0] idx;
    logic        in_range;
    logic        be_ok;
    logic        acc_ok;

    assign req_ready = (state == ST_IDLE) && !rst;
    assign accept    = req_valid && req_ready;

    // The edge that enters RESP performs the access. A reset on that edge
    // wins, so a request pending in WAIT never writes.
    always_comb begin
        access = 1'b0;
        if (!rst) begin
            case (state)
                ST_IDLE: access = accept && (WAIT_CYCLES == 0);
                ST_WAIT: access = (wait_cnt == 4'd0);
                default: access = 1'b0;
            endcase
        end
    end

    // With zero wait states the access happens on the accept edge itself,
    // before the latches hold the request, so the live inputs are used.
    always_comb begin
        if (state == ST_IDLE) begin
            acc_we   = req_we;
            acc_addr = addr_to_mem;
            acc_be   = be;
            acc_data = data_to_mem;
        end else begin
            acc_we   = lat_we;
            acc_addr = lat_addr;
            acc_be   = lat_be;
            acc_data = lat_data;
        end
    end

    // 30-bit wrap subtraction: addresses below BASE_WORD wrap to a large
    // index and therefore land out of range.
    assign idx_full = acc_addr - BASE_WORD;
    assign in_range = (idx_full >> ADDR_WIDTH) == '0;
    assign idx      = idx_full[ADDR_WIDTH-1:0];

    // Only naturally aligned byte, halfword and word masks are legal.
    always_comb begin
        case (acc_be)
            4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b1100, 4'b1111: be_ok = 1'b1;
            default:                   be_ok = 1'b0;
        endcase
    end

    assign acc_ok = be_ok && in_range;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            wait_cnt      <= '0;
            resp_valid    <= 1'b0;
            resp_err      <= 1'b0;
            data_from_mem <= '0;
            lat_we        <= 1'b0;
            lat_addr      <= '0;
            lat_be        <= '0;
            lat_data      <= '0;
        end else begin
            resp_valid <= access;

            // Read-before-write: a store response carries the old word.
            if (access) begin
                data_from_mem <= acc_ok ? mem[idx] : '0;
                resp_err      <= !acc_ok;
            end

            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        lat_we   <= req_we;
                        lat_addr <= addr_to_mem;
                        lat_be   <= be;
                        lat_data <= data_to_mem;
                        if (WAIT_CYCLES == 0) begin
                            state <= ST_RESP;
                        end else begin
                            state    <= ST_WAIT;
                            wait_cnt <= WAIT_LOAD;
                        end
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        state <= ST_RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // RAM is deliberately not cleared by reset.
    always_ff @(posedge clk) begin
        if (access && acc_ok && acc_we) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (acc_be[i]) begin
                    mem[idx][8*i +: 8] <= acc_data[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
//
// Two responders share one clock: instance 0 has no wait states and base 0,
// instance 1 has three wait states and a non-zero base. A word-level model
// (associative array keyed by RAM offset) predicts every response; a single
// compare process checks req_ready / resp_valid every cycle and the response
// payload whenever resp_valid is high.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

    localparam int unsigned AW    = 10;
    localparam logic [29:0] BASE1 = 30'h100;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst       [2] = '{1'b1, 1'b1};
    logic        req_valid [2] = '{1'b0, 1'b0};
    logic        req_we    [2];
    logic [29:0] addr      [2];
    logic [3:0]  be        [2];
    logic [31:0] wdata     [2];
    logic        req_ready [2];
    logic [31:0] rdata     [2];
    logic        resp_valid[2];
    logic        resp_err  [2];

    dmem_responder #(.ADDR_WIDTH(AW), .BASE_WORD(30'h0), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_we(req_we[0]), .addr_to_mem(addr[0]), .be(be[0]), .data_to_mem(wdata[0]),
        .data_from_mem(rdata[0]), .resp_valid(resp_valid[0]), .resp_err(resp_err[0])
    );

    dmem_responder #(.ADDR_WIDTH(AW), .BASE_WORD(BASE1), .WAIT_CYCLES(3)) u_dut1 (
        .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_we(req_we[1]), .addr_to_mem(addr[1]), .be(be[1]), .data_to_mem(wdata[1]),
        .data_from_mem(rdata[1]), .resp_valid(resp_valid[1]), .resp_err(resp_err[1])
    );

    int unsigned wait_of[2] = '{0, 3};
    logic [29:0] base_of[2] = '{30'h0, BASE1};

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Expected response for the request in flight on each instance.
    bit          pend [2] = '{1'b0, 1'b0};
    int          due  [2];
    logic [31:0] exp_d[2];
    bit          exp_e[2];
    bit          exp_c[2];

    // Model RAM: key = instance*4096 + RAM offset; absent = never fully written.
    logic [31:0] mm [int unsigned];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic bit be_legal(input logic [3:0] b);
        return b inside {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
    endfunction

    // Predicts the response for a request and applies its effect to mm.
    task automatic model(input int d, input bit we, input logic [29:0] a,
                         input logic [3:0] b, input logic [31:0] wd);
        logic [63:0] span;
        logic [63:0] off;
        int unsigned k;
        logic [31:0] w;
        span = 64'd1 << 30;
        off  = ({34'd0, a} + span - {34'd0, base_of[d]}) % span;
        if (be_legal(b) && off < (64'd1 << AW)) begin
            k = d * 4096 + int'(off[31:0]);
            exp_e[d] = 1'b0;
            if (mm.exists(k)) begin
                exp_d[d] = mm[k];
                exp_c[d] = 1'b1;
                w        = mm[k];
            end else begin
                exp_d[d] = '0;
                exp_c[d] = 1'b0;
                w        = '0;
            end
            if (we) begin
                for (int i = 0; i < 4; i++)
                    if (b[i]) w[8*i +: 8] = wd[8*i +: 8];
                if (mm.exists(k) || b == 4'hF) mm[k] = w;
            end
        end else begin
            exp_e[d] = 1'b1;
            exp_d[d] = '0;
            exp_c[d] = 1'b1;
        end
    endtask

    // Every cycle: ready and strobe must match the model's timeline.
    always @(negedge clk) begin
        if (cyc > 0) begin
            for (int d = 0; d < 2; d++) begin
                bit exp_rv;
                exp_rv = pend[d] && (cyc == due[d]);
                chk($sformatf("req_ready%0d", d), {31'd0, req_ready[d]}, {31'd0, !rst[d] && !pend[d]});
                chk($sformatf("resp_valid%0d", d), {31'd0, resp_valid[d]}, {31'd0, exp_rv});
                if (resp_valid[d] && exp_rv) begin
                    chk($sformatf("resp_err%0d", d), {31'd0, resp_err[d]}, {31'd0, exp_e[d]});
                    if (exp_c[d]) chk($sformatf("resp_data%0d", d), rdata[d], exp_d[d]);
                    pend[d] = 1'b0;
                end
            end
        end
    end

    task automatic scramble(input int d);
        req_we[d] = 1'($urandom);
        addr[d]   = 30'($urandom);
        be[d]     = 4'($urandom);
        wdata[d]  = $urandom;
    endtask

    task automatic issue(input int d, input bit we, input logic [29:0] a, input logic [3:0] b,
                         input logic [31:0] wd, output logic [31:0] rd, output bit re,
                         output int lat);
        int e0;
        bit ok;
        rd  = '0;
        re  = 1'b0;
        lat = -1;
        @(posedge clk); #1;
        req_we[d] = we; addr[d] = a; be[d] = b; wdata[d] = wd; req_valid[d] = 1'b1;
        ok = 1'b0;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (req_ready[d]) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            chk("accept_timeout", 32'd0, 32'd1);
            req_valid[d] = 1'b0;
            return;
        end
        model(d, we, a, b, wd);
        @(posedge clk); #1;
        e0 = cyc;
        pend[d] = 1'b1;
        due[d]  = cyc + int'(wait_of[d]);
        req_valid[d] = 1'b0;
        scramble(d);
        ok = 1'b0;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (resp_valid[d]) begin ok = 1'b1; break; end
            scramble(d);
        end
        if (!ok) begin
            chk("resp_timeout", 32'd0, 32'd1);
            pend[d] = 1'b0;
            return;
        end
        rd  = rdata[d];
        re  = resp_err[d];
        lat = cyc - e0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    logic [31:0] rd;
    bit          re;
    int          lat;
    bit          ok;

    initial begin
        for (int d = 0; d < 2; d++) scramble(d);
        repeat (3) @(posedge clk);
        #1;
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("reset_data", rdata[d], 32'h0);
            chk("reset_err", {31'd0, resp_err[d]}, 32'd0);
        end

        // Full-word store, read-before-write, then load with zero wait.
        issue(0, 1'b1, 30'h004, 4'hF, 32'h0, rd, re, lat);
        issue(0, 1'b1, 30'h004, 4'hF, 32'hDEADBEEF, rd, re, lat);
        chk("t1_store_old", rd, 32'h0);
        chk("t1_store_err", {31'd0, re}, 32'd0);
        issue(0, 1'b0, 30'h004, 4'hF, 32'h0, rd, re, lat);
        chk("t1_load", rd, 32'hDEADBEEF);
        chk("t1_latency", lat, 0);

        // Single-lane merge.
        issue(0, 1'b1, 30'h008, 4'hF, 32'h11223344, rd, re, lat);
        issue(0, 1'b1, 30'h008, 4'b0100, 32'hAAAAAAAA, rd, re, lat);
        chk("t2_store_old", rd, 32'h11223344);
        issue(0, 1'b0, 30'h008, 4'hF, 32'h0, rd, re, lat);
        chk("t2_load", rd, 32'h11AA3344);

        // Halfword merges.
        issue(0, 1'b1, 30'h008, 4'b1100, 32'h55665566, rd, re, lat);
        issue(0, 1'b1, 30'h008, 4'b0011, 32'h77887788, rd, re, lat);
        issue(0, 1'b0, 30'h008, 4'hF, 32'h0, rd, re, lat);
        chk("t3_load", rd, 32'h55667788);

        // Three wait states; inputs are scrambled while the request is in flight.
        issue(1, 1'b1, BASE1 + 30'd5, 4'hF, 32'hCAFEF00D, rd, re, lat);
        issue(1, 1'b0, BASE1 + 30'd5, 4'hF, 32'h0, rd, re, lat);
        chk("t4_load", rd, 32'hCAFEF00D);
        chk("t4_latency", lat, 3);

        // Illegal byte mask and out-of-range address both fault without writing.
        issue(0, 1'b1, 30'h004, 4'b0101, 32'h12345678, rd, re, lat);
        chk("t5_bad_be_err", {31'd0, re}, 32'd1);
        chk("t5_bad_be_data", rd, 32'h0);
        issue(0, 1'b0, 30'd1024, 4'hF, 32'h0, rd, re, lat);
        chk("t5_oor_err", {31'd0, re}, 32'd1);
        chk("t5_oor_data", rd, 32'h0);
        issue(1, 1'b0, BASE1 - 30'd1, 4'hF, 32'h0, rd, re, lat);
        chk("t5_below_base_err", {31'd0, re}, 32'd1);
        issue(0, 1'b0, 30'h004, 4'hF, 32'h0, rd, re, lat);
        chk("t5_reread", rd, 32'hDEADBEEF);

        // Reset during WAIT drops the pending store.
        issue(1, 1'b1, BASE1 + 30'd7, 4'hF, 32'h0BADC0DE, rd, re, lat);
        @(posedge clk); #1;
        req_we[1] = 1'b1; addr[1] = BASE1 + 30'd7; be[1] = 4'hF; wdata[1] = 32'hFFFF0000;
        req_valid[1] = 1'b1;
        ok = 1'b0;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (req_ready[1]) begin ok = 1'b1; break; end
        end
        if (!ok) chk("t6_accept_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        pend[1] = 1'b1;
        due[1]  = cyc + 1000;
        @(posedge clk); #1;
        rst[1] = 1'b1;
        @(posedge clk); #1;
        rst[1] = 1'b0;
        pend[1] = 1'b0;
        @(negedge clk);
        chk("t6_ready_after_rst", {31'd0, req_ready[1]}, 32'd1);
        repeat (4) @(posedge clk);
        issue(1, 1'b0, BASE1 + 30'd7, 4'hF, 32'h0, rd, re, lat);
        chk("t6_word_kept", rd, 32'h0BADC0DE);

        // Randomized traffic around both ends of the mapped window.
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 24; i++) begin
                int unsigned off;
                off = (i < 16) ? i : 1000 + i;
                issue(d, 1'b1, 30'(base_of[d] + 30'(off)), 4'hF, $urandom, rd, re, lat);
            end
            for (int i = 0; i < 150; i++) begin
                int unsigned r;
                int unsigned off;
                logic [3:0]  b;
                logic [3:0]  legal [7];
                legal = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
                r = $urandom % 10;
                if (r < 6)      off = $urandom % 16;
                else if (r < 9) off = 1016 + $urandom % 8;
                else begin
                    case ($urandom % 4)
                        0:       off = 1024;
                        1:       off = 1027;
                        2:       off = 32'h3FFF_FFFF;
                        default: off = 32'h3FFF_FFFE;
                    endcase
                end
                b = ($urandom % 8 < 6) ? legal[$urandom % 7] : 4'($urandom);
                issue(d, 1'($urandom), 30'(base_of[d] + 30'(off)), b, $urandom, rd, re, lat);
                repeat ($urandom % 3) @(posedge clk);
            end
        end

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
